// File: rtl/comparator_pkg.sv
// rtl/comparator_pkg.sv - shared types and pin-map constants for the serial wide comparator
package comparator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Running verdict of the MSB-first compare; UND means all nibbles so far matched.
    typedef enum logic [1:0] {
        DEC_UND = 2'd0,
        DEC_GT  = 2'd1,
        DEC_LT  = 2'd2
    } decision_e;

    // uio_in bit positions
    localparam int UIO_VALID  = 0;
    localparam int UIO_SIGNED = 1;
    localparam int UIO_CLEAR  = 2;

    // uo_out bit positions
    localparam int UO_GT       = 0;
    localparam int UO_EQ       = 1;
    localparam int UO_LT       = 2;
    localparam int UO_DONE     = 3;
    localparam int UO_BUSY     = 4;
    localparam int UO_BEAT_LSB = 5;

    localparam logic [7:0] UIO_OE_MASK = 8'hF0;

endpackage

// File: rtl/nibble_cmp.sv
// rtl/nibble_cmp.sv - combinational 4-bit magnitude compare, unsigned or two's complement
//
// Ports:
//   a_i, b_i     nibbles to compare
//   is_signed_i  treat nibble MSB as sign bit
//   gt_o, lt_o   a > b, a < b (both low when equal)
module nibble_cmp (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       is_signed_i,
    output logic       gt_o,
    output logic       lt_o
);

    // Flipping the sign bit maps two's complement order onto unsigned order.
    logic [3:0] a_x;
    logic [3:0] b_x;

    assign a_x  = {a_i[3] ^ is_signed_i, a_i[2:0]};
    assign b_x  = {b_i[3] ^ is_signed_i, b_i[2:0]};
    assign gt_o = (a_x > b_x);
    assign lt_o = (a_x < b_x);

endmodule

// File: rtl/comparator_serial_wide.sv
// rtl/comparator_serial_wide.sv - WIDTH-bit MSB-first serial comparator on the Tiny Tapeout pin interface
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   ena         design selected; all state holds while low
//   ui_in       [7:4] A nibble, [3:0] B nibble
//   uio_in      [0] valid, [1] signed_mode, [2] clear
//   uo_out      [0] gt, [1] eq, [2] lt, [3] done, [4] busy, [7:5] beat index
//   uio_out     [7:4] completed-compare count, [3:0] zero
//   uio_oe      constant 8'hF0
module comparator_serial_wide
    import comparator_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int BEATS  = WIDTH / 4;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    state_e            state_q, state_d;
    decision_e         dec_q, dec_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              gt_q, gt_d;
    logic              eq_q, eq_d;
    logic              lt_q, lt_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic      first_beat;
    logic      last_beat;
    logic      nib_gt;
    logic      nib_lt;
    decision_e beat_dec;
    logic      unused_uio;

    assign unused_uio = ^uio_in[7:3];

    // Any beat accepted outside RUN starts a fresh compare.
    assign first_beat = (state_q != ST_RUN);
    assign last_beat  = first_beat ? (BEATS == 1) : (beat_q == LAST_BEAT);

    // Sign only matters for the most significant nibble.
    nibble_cmp u_nibble_cmp (
        .a_i         (ui_in[7:4]),
        .b_i         (ui_in[3:0]),
        .is_signed_i (first_beat & uio_in[UIO_SIGNED]),
        .gt_o        (nib_gt),
        .lt_o        (nib_lt)
    );

    // A decided verdict from a more significant nibble wins over this one.
    always_comb begin
        beat_dec = DEC_UND;
        if (!first_beat && dec_q != DEC_UND) begin
            beat_dec = dec_q;
        end else if (nib_gt) begin
            beat_dec = DEC_GT;
        end else if (nib_lt) begin
            beat_dec = DEC_LT;
        end
    end

    always_comb begin
        state_d = state_q;
        dec_d   = dec_q;
        beat_d  = beat_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        done_d  = done_q;
        count_d = count_q;
        if (ena) begin
            if (uio_in[UIO_CLEAR]) begin
                state_d = ST_IDLE;
                dec_d   = DEC_UND;
                beat_d  = '0;
                gt_d    = 1'b0;
                eq_d    = 1'b0;
                lt_d    = 1'b0;
                done_d  = 1'b0;
            end else if (uio_in[UIO_VALID]) begin
                dec_d  = beat_dec;
                gt_d   = 1'b0;
                eq_d   = 1'b0;
                lt_d   = 1'b0;
                done_d = 1'b0;
                if (last_beat) begin
                    state_d = ST_DONE;
                    beat_d  = '0;
                    gt_d    = (beat_dec == DEC_GT);
                    lt_d    = (beat_dec == DEC_LT);
                    eq_d    = (beat_dec == DEC_UND);
                    done_d  = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end else begin
                    state_d = ST_RUN;
                    beat_d  = first_beat ? BEAT_W'(1) : beat_q + BEAT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dec_q   <= DEC_UND;
            beat_q  <= '0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            dec_q   <= dec_d;
            beat_q  <= beat_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        uo_out                         = 8'h00;
        uo_out[UO_GT]                  = gt_q;
        uo_out[UO_EQ]                  = eq_q;
        uo_out[UO_LT]                  = lt_q;
        uo_out[UO_DONE]                = done_q;
        uo_out[UO_BUSY]                = (state_q == ST_RUN);
        uo_out[UO_BEAT_LSB +: 3]       = 3'(beat_q);
    end

    assign uio_out = {count_q, 4'b0000};
    assign uio_oe  = UIO_OE_MASK;

endmodule

// File: tb/tb_comparator_serial_wide.sv
// tb/tb_comparator_serial_wide.sv - self-checking bench for comparator_serial_wide (WIDTH=32 and WIDTH=4)
module tb_comparator_serial_wide;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       ena32, ena4;
    logic [7:0] ui32, uio32, ui4, uio4;
    wire  [7:0] uo32, uio_out32, uio_oe32;
    wire  [7:0] uo4, uio_out4, uio_oe4;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt32    = 0;
    int cnt4     = 0;
    logic [7:0] exp32 = 8'h00;
    logic [7:0] exp4  = 8'h00;

    comparator_serial_wide #(.WIDTH(32), .CNT_W(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .ena(ena32), .ui_in(ui32), .uio_in(uio32),
        .uo_out(uo32), .uio_out(uio_out32), .uio_oe(uio_oe32)
    );

    comparator_serial_wide #(.WIDTH(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena4), .ui_in(ui4), .uio_in(uio4),
        .uo_out(uo4), .uio_out(uio_out4), .uio_oe(uio_oe4)
    );

    // Reference verdict from whole operands: returns {lt, eq, gt}.
    function automatic logic [2:0] ref_cmp(input logic [31:0] a, input logic [31:0] b,
                                           input bit sgn, input int w);
        longint sa, sb;
        sa = longint'(a);
        sb = longint'(b);
        if (sgn) begin
            if (a[w-1]) sa = sa - (longint'(1) << w);
            if (b[w-1]) sb = sb - (longint'(1) << w);
        end
        if (sa > sb) return 3'b001;
        if (sa < sb) return 3'b100;
        return 3'b010;
    endfunction

    // Streams beats k0..k1-1 of a/b into dut32; gap 0 none, 1 before every beat, 2 random.
    task automatic run32(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                         input int gap, input int k0, input int k1, input string name);
        for (int k = k0; k < k1; k++) begin
            if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) begin
                ui32  = 8'($urandom);
                uio32 = {5'($urandom), 1'b0, 1'($urandom), 1'b0};
                @(negedge clk);
                n_checks++;
                if (uo32 !== exp32 || uio_out32 !== {4'(cnt32), 4'h0}) begin
                    n_fail++;
                    $display("FAIL %s gap k=%0d uo=%h exp=%h uio_out=%h exp=%h",
                             name, k, uo32, exp32, uio_out32, {4'(cnt32), 4'h0});
                end
            end
            ui32  = {a[31-4*k -: 4], b[31-4*k -: 4]};
            uio32 = {5'($urandom), 1'b0, (k == 0) ? sgn : 1'($urandom), 1'b1};
            @(negedge clk);
            if (k == 7) begin
                cnt32 = (cnt32 + 1) % 16;
                exp32 = {3'b000, 1'b0, 1'b1, ref_cmp(a, b, sgn, 32)};
            end else begin
                exp32 = {3'(k + 1), 1'b1, 1'b0, 3'b000};
            end
            n_checks++;
            if (uo32 !== exp32 || uio_out32 !== {4'(cnt32), 4'h0}) begin
                n_fail++;
                $display("FAIL %s beat k=%0d uo=%h exp=%h uio_out=%h exp=%h",
                         name, k, uo32, exp32, uio_out32, {4'(cnt32), 4'h0});
            end
        end
        uio32 = 8'h00;
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input bit sgn, input string name);
        ui4  = {a, b};
        uio4 = {5'($urandom), 1'b0, sgn, 1'b1};
        @(negedge clk);
        cnt4 = (cnt4 + 1) % 16;
        exp4 = {3'b000, 1'b0, 1'b1, ref_cmp({28'h0, a}, {28'h0, b}, sgn, 4)};
        n_checks++;
        if (uo4 !== exp4 || uio_out4 !== {4'(cnt4), 4'h0}) begin
            n_fail++;
            $display("FAIL %s a=%h b=%h uo=%h exp=%h uio_out=%h exp=%h",
                     name, a, b, uo4, exp4, uio_out4, {4'(cnt4), 4'h0});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ena32 = 1'b1; ena4 = 1'b1;
        ui32 = 8'h00; uio32 = 8'h00; ui4 = 8'h00; uio4 = 8'h00;
        #12;
        n_checks++;
        if (uo32 !== 8'h00 || uio_out32 !== 8'h00 || uio_oe32 !== 8'hF0) begin
            n_fail++;
            $display("FAIL reset32 uo=%h uio_out=%h oe=%h exp 00 00 f0", uo32, uio_out32, uio_oe32);
        end
        n_checks++;
        if (uo4 !== 8'h00 || uio_out4 !== 8'h00 || uio_oe4 !== 8'hF0) begin
            n_fail++;
            $display("FAIL reset4 uo=%h uio_out=%h oe=%h exp 00 00 f0", uo4, uio_out4, uio_oe4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        run32(32'h12345678, 32'h12345679, 1'b0, 0, 0, 8, "unsigned");
        n_checks++;
        if (uo32[3:0] !== 4'b1100 || uio_out32[7:4] !== 4'd1) begin
            n_fail++;
            $display("FAIL unsigned_example flags=%b count=%0d exp 1100 1", uo32[3:0], uio_out32[7:4]);
        end
    endtask

    task automatic test_signed_vs_unsigned();
        run32(32'h80000000, 32'h00000001, 1'b1, 0, 0, 8, "signed");
        n_checks++;
        if (uo32[2:0] !== 3'b100) begin
            n_fail++;
            $display("FAIL signed_lt flags=%b exp 100", uo32[2:0]);
        end
        run32(32'h80000000, 32'h00000001, 1'b0, 0, 0, 8, "unsigned_rpt");
        n_checks++;
        if (uo32[2:0] !== 3'b001 || uio_out32[7:4] !== 4'd3) begin
            n_fail++;
            $display("FAIL unsigned_gt flags=%b count=%0d exp 001 3", uo32[2:0], uio_out32[7:4]);
        end
    endtask

    task automatic test_gapped_equal();
        run32(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1, 0, 8, "gapped_eq");
        n_checks++;
        if (uo32[3:0] !== 4'b1010) begin
            n_fail++;
            $display("FAIL gapped_eq flags=%b exp 1010", uo32[3:0]);
        end
    endtask

    task automatic test_clear();
        run32(32'hCAFEF00D, 32'h0BADCAFE, 1'b0, 0, 0, 3, "pre_clear");
        ui32  = 8'h5A;
        uio32 = 8'h05;
        @(negedge clk);
        uio32 = 8'h00;
        exp32 = 8'h00;
        n_checks++;
        if (uo32 !== exp32 || uio_out32 !== {4'(cnt32), 4'h0}) begin
            n_fail++;
            $display("FAIL clear uo=%h exp=%h uio_out=%h exp=%h", uo32, exp32, uio_out32, {4'(cnt32), 4'h0});
        end
        run32(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 0, 0, 8, "post_clear");
    endtask

    task automatic test_ena_low();
        run32(32'h00F00000, 32'h00E00000, 1'b1, 0, 0, 4, "pre_ena");
        ena32 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ui32  = 8'($urandom);
            uio32 = 8'h07;
            @(negedge clk);
            n_checks++;
            if (uo32 !== exp32 || uio_out32 !== {4'(cnt32), 4'h0}) begin
                n_fail++;
                $display("FAIL ena_low_hold i=%0d uo=%h exp=%h", i, uo32, exp32);
            end
        end
        ena32 = 1'b1;
        uio32 = 8'h00;
        run32(32'h00F00000, 32'h00E00000, 1'b1, 0, 4, 8, "post_ena");
    endtask

    task automatic test_reset_mid();
        run32(32'h11112222, 32'h11113333, 1'b0, 0, 0, 5, "pre_reset");
        #2 rst_n = 1'b0;
        #1;
        cnt32 = 0; cnt4 = 0; exp32 = 8'h00; exp4 = 8'h00;
        n_checks++;
        if (uo32 !== 8'h00 || uio_out32 !== 8'h00 || uio_oe32 !== 8'hF0 || uo4 !== 8'h00 || uio_out4 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid uo=%h uio_out=%h oe=%h uo4=%h uio_out4=%h",
                     uo32, uio_out32, uio_oe32, uo4, uio_out4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        bit sgn;
        for (int n = 0; n < 12; n++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 0) b = $urandom;
            else b = a ^ (32'($urandom_range(0, 15)) << (4 * $urandom_range(0, 7)));
            sgn = 1'($urandom);
            run32(a, b, sgn, 2, 0, 8, "random");
        end
    endtask

    task automatic test_width4();
        run4(4'h9, 4'h3, 1'b1, "w4_single");
        uio4 = 8'h00;
        n_checks++;
        if (uo4[3:0] !== 4'b1100) begin
            n_fail++;
            $display("FAIL w4_signed_lt flags=%b exp 1100", uo4[3:0]);
        end
        @(negedge clk);
        rst_n = 1'b0;
        cnt4 = 0; cnt32 = 0; exp4 = 8'h00; exp32 = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            run4(4'($urandom), 4'($urandom), 1'($urandom), "w4_back_to_back");
        end
        uio4 = 8'h00;
        n_checks++;
        if (uio_out4[7:4] !== 4'd1) begin
            n_fail++;
            $display("FAIL w4_count_wrap count=%0d exp 1", uio_out4[7:4]);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed_vs_unsigned();
        test_gapped_equal();
        test_clear();
        test_ena_low();
        test_reset_mid();
        test_random();
        test_width4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
